dct8_pair_feeder: RTL and testbench
===================================

Name: dct8_pair_feeder

Overview:
- Input staging stage directly upstream of the 8-point butterfly PE.
- Accepts 8-sample frames as a serial valid/ready stream.
- Buffers each frame in a ping-pong (two-bank) register memory.
- Issues the four mirrored stage-1 operand pairs (x[i], x[7-i]), i=0..3, one pair per cycle, with a per-pair enable pulse that drives the butterfly's enable.

Parameters:
- DATA_W, default DCT8_IN_W (16): sample width, signed two's complement; matches the butterfly operand width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  feeder can accept a sample this cycle
- in_data  in  DATA_W  signed input sample; the frame is in natural order x[0]..x[7]
- bf_ready  in  1  downstream may take a pair this cycle (0 = stall issue)
- bf_enable  out  1  registered one-cycle pulse per issued pair
- bf_a  out  DATA_W  x[i] of the issued pair
- bf_b  out  DATA_W  x[7-i] of the issued pair
- bf_idx  out  2  pair index i
- bf_last  out  1  high with bf_enable when i=3 (frame complete)

Behaviour:
- Storage and bookkeeping:
  - Two banks, each 8 x DATA_W.
  - full[1:0] flags, one per bank.
  - Write side: wr_bank (1b), wr_cnt (3b).
  - Read side: rd_bank (1b), rd_cnt (2b), FSM {IDLE, ISSUE}.
- Write side:
  - in_ready = !full[wr_bank]. This is combinational from registered flags only; it has no path from in_valid or bf_ready.
  - A sample is accepted on a rising edge where in_valid && in_ready. It is stored at bank[wr_bank][wr_cnt], and wr_cnt then increments.
  - Accepting with wr_cnt==7 sets full[wr_bank], toggles wr_bank and wraps wr_cnt to 0.
  - No data is ever dropped or overwritten; a sender holding in_valid while in_ready=0 waits.
- Read FSM:
  - IDLE: if full[rd_bank] && bf_ready, issue pair 0, set rd_cnt=1, go to ISSUE. Otherwise bf_enable=0.
  - ISSUE: on each edge with bf_ready=1, issue pair rd_cnt and increment rd_cnt. On an edge with bf_ready=0, register bf_enable=0 and hold all other outputs and rd_cnt.
  - Issuing pair 3 clears full[rd_bank] and toggles rd_bank. If full[new rd_bank] is already set, stay in ISSUE with rd_cnt=0, so back-to-back frames produce 8 consecutive pulses with no gap. Otherwise go to IDLE.
- Issue action (all outputs registered): bf_enable=1, bf_a=bank[rd_bank][i], bf_b=bank[rd_bank][7-i], bf_idx=i, bf_last=(i==3).
- When no pair is issued, bf_enable=0 and bf_last=0; bf_a, bf_b and bf_idx hold their last values.
- Latency: 8th sample accepted on edge E0 → pair 0 presented after edge E1 if bf_ready=1 at E1. Pairs 1..3 follow on E2..E4 if bf_ready stays 1.
- Simultaneous events:
  - A write filling one bank and a read freeing the other bank on the same edge are both honoured.
  - A bank is never written while full, so set and clear never collide on the same flag.
- Throughput: 8 samples in per 4 issue cycles; ping-pong sustains in_valid held continuously with in_ready never falling while bf_ready=1.
- Data is copied bit-exact: no arithmetic, no sign change, no scaling (scaling is done in the butterfly).
- Reset (async, any time, including mid-frame or mid-issue):
  - All counters, wr_bank/rd_bank and full flags go to 0; FSM goes to IDLE.
  - bf_enable, bf_last, bf_idx, bf_a and bf_b go to 0.
  - Bank contents need no reset.
  - in_ready reads 1 during and after reset.
  - Partial frames are discarded.

Test Plan:
- Single frame: send 1,2,3,4,5,6,7,8 with bf_ready=1. Required: pairs (1,8),(2,7),(3,6),(4,5) with idx 0..3 on the 4 edges after the 8th accept; bf_last only with (4,5); then bf_enable=0.
- Signed extremes (DATA_W=16): frame -32768,32767,-1,0,1,-2,2,-32768. Required: pairs (-32768,-32768),(32767,2),(-1,-2),(0,1), bit-exact.
- Stall: bf_ready=0 for 3 cycles after pair 1 is issued. Required: bf_enable=0 and bf_a/bf_b/bf_idx hold (2,7)/1 during the stall; then pairs 2 and 3 issue with no pair skipped or repeated.
- Back-pressure: two full frames (1..8, 11..18) with bf_ready=0. Required: in_ready=0 after the 16th accept, and the 17th sample waits. Releasing bf_ready gives 8 consecutive enables (1,8)…(14,15), and in_ready returns to 1 the cycle after pair (4,5) is issued.
- Streaming: continuous in_valid for 4 frames with bf_ready=1. Required: in_ready is never 0; exactly 16 enables; frame order preserved.
- Reset mid-frame: assert rst_n=0 after 5 samples, release, then send 21..28. Required: during reset all outputs are 0 and in_ready=1; afterwards the pairs are (21,28),(22,27),(23,26),(24,25), with no pair taken from the discarded samples.

Source files
------------

// File: rtl/dct8_pair_feeder.sv
// dct8_pair_feeder
//   Input staging for the 8-point butterfly PE. Serial 8-sample frames are
//   captured into a two-bank (ping-pong) register memory. Each full bank is
//   replayed as the four mirrored stage-1 pairs (x[i], x[7-i]), i=0..3, one
//   pair per cycle, each with a one-cycle enable pulse.
// Ports
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   sample handshake, in_data = signed sample, x[0] first
//   bf_ready            downstream may take a pair this cycle
//   bf_enable           registered pulse per issued pair
//   bf_a/bf_b           x[i] / x[7-i] of the issued pair
//   bf_idx, bf_last     pair index i, high with the i=3 pair
module dct8_pair_feeder #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              bf_ready,
  output logic              bf_enable,
  output logic [DATA_W-1:0] bf_a,
  output logic [DATA_W-1:0] bf_b,
  output logic [1:0]        bf_idx,
  output logic              bf_last
);

  typedef enum logic {IDLE, ISSUE} state_e;

  logic [1:0][7:0][DATA_W-1:0] mem_q;
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic [2:0]        wr_cnt_q, wr_cnt_d;
  logic              rd_bank_q;
  logic [1:0]        rd_cnt_q;
  state_e            state_q;

  logic              wr_fire, rd_fire, rd_done;
  logic [1:0]        pidx;
  logic [2:0]        lo_sel, hi_sel;

  logic              en_q, last_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [1:0]        idx_q;

  // Ready depends only on the registered full flags.
  assign in_ready = !full_q[wr_bank_q];
  assign wr_fire  = in_valid && in_ready;

  // In ISSUE the read bank is full by construction; IDLE waits for it.
  assign rd_fire  = bf_ready && ((state_q == ISSUE) || full_q[rd_bank_q]);
  assign pidx     = (state_q == ISSUE) ? rd_cnt_q : 2'd0;
  assign rd_done  = rd_fire && (pidx == 2'd3);
  assign lo_sel   = {1'b0, pidx};
  assign hi_sel   = 3'd7 - lo_sel;

  // Write bookkeeping plus full flags. The write bank is never full when
  // written and the read bank is full while read, so a set and a clear on
  // the same edge always target different banks.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + 3'd1;
      if (wr_cnt_q == 3'd7) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end
    if (rd_done) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // Sample storage; contents are don't-care until their bank fills.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_bank_q][wr_cnt_q] <= in_data;
  end

  // Read FSM with registered pair outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
      en_q      <= 1'b0;
      last_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
    end else if (rd_fire) begin
      en_q     <= 1'b1;
      last_q   <= (pidx == 2'd3);
      a_q      <= mem_q[rd_bank_q][lo_sel];
      b_q      <= mem_q[rd_bank_q][hi_sel];
      idx_q    <= pidx;
      rd_cnt_q <= pidx + 2'd1;
      if (pidx == 2'd3) begin
        rd_bank_q <= !rd_bank_q;
        // Chain straight into the other bank when it is already full.
        state_q   <= full_q[!rd_bank_q] ? ISSUE : IDLE;
      end else begin
        state_q   <= ISSUE;
      end
    end else begin
      en_q   <= 1'b0;
      last_q <= 1'b0;
    end
  end

  assign bf_enable = en_q;
  assign bf_last   = last_q;
  assign bf_a      = a_q;
  assign bf_b      = b_q;
  assign bf_idx    = idx_q;

endmodule

// File: tb/tb_dct8_pair_feeder.sv
// Bench for dct8_pair_feeder: a frame-level reference model (queues of
// complete frames, a pair pointer) predicts every output cycle; directed
// cases pin the model with literal pair tables.
module tb_dct8_pair_feeder;
  localparam int DATA_W = 16;
  typedef logic [DATA_W-1:0] smp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  smp_t       in_data = '0;
  logic       bf_ready = 1'b0;
  logic       bf_enable, bf_last;
  smp_t       bf_a, bf_b;
  logic [1:0] bf_idx;

  always #5 clk = ~clk;

  dct8_pair_feeder #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bf_ready(bf_ready), .bf_enable(bf_enable),
    .bf_a(bf_a), .bf_b(bf_b), .bf_idx(bf_idx), .bf_last(bf_last)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: part_q holds the frame being written, frm_q holds complete
  // frames (8 samples each) in arrival order, pair_i is the next pair of
  // the head frame. At most two complete frames fit.
  smp_t part_q[$];
  smp_t frm_q[$];
  int   pair_i = 0;
  logic e_en = 0, e_last = 0;
  smp_t e_a = '0, e_b = '0;
  logic [1:0] e_idx = '0;

  smp_t cap_a[$], cap_b[$];
  int   cap_idx[$];
  logic cap_last[$];
  smp_t tx_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    part_q.delete();
    frm_q.delete();
    pair_i = 0;
    e_en = 0; e_last = 0; e_a = '0; e_b = '0; e_idx = '0;
  endtask

  task automatic clear_caps();
    cap_a.delete(); cap_b.delete(); cap_idx.delete(); cap_last.delete();
  endtask

  // One clock: drive, predict, clock, compare. Called at posedge+1.
  task automatic cycle(input logic v, input smp_t d, input logic r, output logic acc);
    logic exp_rdy, iss;
    in_valid = v; in_data = d; bf_ready = r;
    exp_rdy = (frm_q.size() < 16);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    acc = v && exp_rdy;
    iss = r && (frm_q.size() >= 8);
    if (iss) begin
      e_en = 1; e_last = (pair_i == 3);
      e_a = frm_q[pair_i]; e_b = frm_q[7 - pair_i]; e_idx = 2'(pair_i);
      if (pair_i == 3) begin
        for (int k = 0; k < 8; k++) void'(frm_q.pop_front());
        pair_i = 0;
      end else pair_i++;
    end else begin
      e_en = 0; e_last = 0;
    end
    if (acc) begin
      part_q.push_back(d);
      if (part_q.size() == 8) begin
        foreach (part_q[k]) frm_q.push_back(part_q[k]);
        part_q.delete();
      end
    end
    @(posedge clk); #1;
    chk("bf_enable", {31'd0, bf_enable}, {31'd0, e_en});
    chk("bf_last",   {31'd0, bf_last},   {31'd0, e_last});
    chk("bf_a",      {16'd0, bf_a},      {16'd0, e_a});
    chk("bf_b",      {16'd0, bf_b},      {16'd0, e_b});
    chk("bf_idx",    {30'd0, bf_idx},    {30'd0, e_idx});
    if (bf_enable) begin
      cap_a.push_back(bf_a); cap_b.push_back(bf_b);
      cap_idx.push_back(int'(bf_idx)); cap_last.push_back(bf_last);
    end
  endtask

  // Send tx_q with random valid/ready percentages, bounded in cycles.
  task automatic run(input int vpct, input int rpct, input int budget);
    logic acc, v, r;
    int n = 0;
    while (tx_q.size() > 0 && n < budget) begin
      v = ($urandom_range(99) < vpct);
      r = ($urandom_range(99) < rpct);
      cycle(v, tx_q[0], r, acc);
      if (acc) void'(tx_q.pop_front());
      n++;
    end
    if (tx_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL run_timeout: %0d samples left, expected 0", tx_q.size());
      tx_q.delete();
    end
  endtask

  task automatic drain();
    logic acc;
    int n = 0;
    while (frm_q.size() > 0 && n < 64) begin
      cycle(1'b0, '0, 1'b1, acc);
      n++;
    end
    n_cmp++;
    if (frm_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d samples pending, expected 0", frm_q.size());
    end
    cycle(1'b0, '0, 1'b1, acc);
    cycle(1'b0, '0, 1'b1, acc);
  endtask

  task automatic chk_caps(input string nm, input smp_t ea[$], input smp_t eb[$]);
    chk({nm, "_npairs"}, cap_a.size(), ea.size());
    for (int k = 0; k < ea.size() && k < cap_a.size(); k++) begin
      chk({nm, "_a"}, {16'd0, cap_a[k]}, {16'd0, ea[k]});
      chk({nm, "_b"}, {16'd0, cap_b[k]}, {16'd0, eb[k]});
      chk({nm, "_idx"}, cap_idx[k], k % 4);
      chk({nm, "_last"}, {31'd0, cap_last[k]}, {31'd0, (k % 4) == 3});
    end
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_rdy"},  {31'd0, in_ready},  32'd1);
    chk({nm, "_en"},   {31'd0, bf_enable}, 32'd0);
    chk({nm, "_last"}, {31'd0, bf_last},   32'd0);
    chk({nm, "_a"},    {16'd0, bf_a},      32'd0);
    chk({nm, "_b"},    {16'd0, bf_b},      32'd0);
    chk({nm, "_idx"},  {30'd0, bf_idx},    32'd0);
  endtask

  initial begin
    logic acc;
    int lows, nen;
    smp_t ea[$], eb[$];

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    rst_n = 1'b1;
    model_reset();

    // Single frame 1..8
    clear_caps();
    for (int k = 1; k <= 8; k++) tx_q.push_back(smp_t'(k));
    run(100, 100, 50);
    drain();
    ea = '{1, 2, 3, 4}; eb = '{8, 7, 6, 5};
    chk_caps("single", ea, eb);

    // Signed extremes
    clear_caps();
    tx_q = '{16'h8000, 16'h7fff, 16'hffff, 16'h0000, 16'h0001, 16'hfffe, 16'h0002, 16'h8000};
    run(100, 100, 50);
    drain();
    ea = '{16'h8000, 16'h7fff, 16'hffff, 16'h0000};
    eb = '{16'h8000, 16'h0002, 16'hfffe, 16'h0001};
    chk_caps("signed", ea, eb);

    // Stall after pair 1
    clear_caps();
    for (int k = 1; k <= 8; k++) cycle(1'b1, smp_t'(k), 1'b0, acc);
    cycle(1'b0, '0, 1'b1, acc);
    cycle(1'b0, '0, 1'b1, acc);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, '0, 1'b0, acc);
      chk("stall_en",  {31'd0, bf_enable}, 32'd0);
      chk("stall_a",   {16'd0, bf_a}, 32'd2);
      chk("stall_b",   {16'd0, bf_b}, 32'd7);
      chk("stall_idx", {30'd0, bf_idx}, 32'd1);
    end
    cycle(1'b0, '0, 1'b1, acc);
    cycle(1'b0, '0, 1'b1, acc);
    drain();
    ea = '{1, 2, 3, 4}; eb = '{8, 7, 6, 5};
    chk_caps("stall", ea, eb);

    // Back-pressure: two frames held, 17th sample waits
    clear_caps();
    for (int k = 1; k <= 8; k++) cycle(1'b1, smp_t'(k), 1'b0, acc);
    for (int k = 11; k <= 18; k++) cycle(1'b1, smp_t'(k), 1'b0, acc);
    chk("bp_rdy_low", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, smp_t'(19), 1'b0, acc);
      chk("bp_17th_wait", {31'd0, acc}, 32'd0);
    end
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, '0, 1'b1, acc);
      chk("bp_burst_en", {31'd0, bf_enable}, 32'd1);
      if (k == 2) chk("bp_rdy_still_low", {31'd0, in_ready}, 32'd0);
      if (k == 3) chk("bp_rdy_back", {31'd0, in_ready}, 32'd1);
    end
    drain();
    ea = '{1, 2, 3, 4, 11, 12, 13, 14}; eb = '{8, 7, 6, 5, 18, 17, 16, 15};
    chk_caps("bp", ea, eb);

    // Streaming: 4 frames, continuous valid, ready always 1
    clear_caps();
    lows = 0;
    for (int k = 0; k < 32; k++) begin
      if (!in_ready) lows++;
      cycle(1'b1, smp_t'(100 + k), 1'b1, acc);
    end
    drain();
    chk("stream_rdy_lows", lows, 0);
    nen = cap_a.size();
    chk("stream_enables", nen, 16);
    for (int k = 0; k < nen && k < 16; k++) begin
      chk("stream_order_a", {16'd0, cap_a[k]}, 32'(100 + 8 * (k / 4) + (k % 4)));
      chk("stream_order_b", {16'd0, cap_b[k]}, 32'(107 + 8 * (k / 4) - (k % 4)));
    end

    // Randomized traffic with random data and back-pressure
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 8 * 6; k++) tx_q.push_back(smp_t'($urandom));
      run(40 + 20 * t, 80 - 20 * t, 2000);
      drain();
    end

    // Reset mid-frame: 5 samples then reset, then 21..28
    clear_caps();
    for (int k = 1; k <= 5; k++) cycle(1'b1, smp_t'(90 + k), 1'b1, acc);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst_async");
    @(posedge clk); #1;
    chk_reset_outs("midrst_hold");
    model_reset();
    rst_n = 1'b1;
    for (int k = 21; k <= 28; k++) tx_q.push_back(smp_t'(k));
    run(100, 100, 50);
    drain();
    ea = '{21, 22, 23, 24}; eb = '{28, 27, 26, 25};
    chk_caps("midrst", ea, eb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
